// File: rtl/round_controller_if.sv
// Bundles the referee's game-side signals: start/health in, round status out.
interface round_controller_if;
  logic       start_btn;
  logic [3:0] p0_health;
  logic [3:0] p1_health;
  logic       finish;
  logic       round_reset;
  logic [4:0] state;
  logic [1:0] countdown;
  logic [6:0] round_time;
  logic [1:0] round_num;
  logic [1:0] p0_wins;
  logic [1:0] p1_wins;
  logic [1:0] round_winner;
  logic [1:0] match_winner;

  // Game logic side: supplies inputs, observes status.
  modport master (
    output start_btn, p0_health, p1_health,
    input  finish, round_reset, state, countdown, round_time,
           round_num, p0_wins, p1_wins, round_winner, match_winner
  );

  // Referee side.
  modport slave (
    input  start_btn, p0_health, p1_health,
    output finish, round_reset, state, countdown, round_time,
           round_num, p0_wins, p1_wins, round_winner, match_winner
  );
endinterface

// File: rtl/round_controller.sv
// Match/round referee on the 2 Hz shield tick: countdown, round clock,
// KO/timeout detection, win tally and best-of-N match flow.
module round_controller #(
  parameter int unsigned ROUND_SECONDS = 60,
  parameter int unsigned WINS_TO_MATCH = 2,
  parameter int unsigned MAX_ROUNDS    = 3,
  parameter int unsigned READY_TICKS   = 6,
  parameter int unsigned OVER_TICKS    = 4
) (
  input logic               slowed_shield_clk,
  input logic               reset,
  round_controller_if.slave bus
);

  localparam int unsigned CNT_MAX = (READY_TICKS > OVER_TICKS) ? READY_TICKS : OVER_TICKS;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [4:0] S_IDLE       = 5'b00001;
  localparam logic [4:0] S_READY      = 5'b00010;
  localparam logic [4:0] S_FIGHT      = 5'b00100;
  localparam logic [4:0] S_ROUND_OVER = 5'b01000;
  localparam logic [4:0] S_MATCH_OVER = 5'b10000;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P0   = 2'b01;
  localparam logic [1:0] W_P1   = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  localparam logic [6:0]       RT_INIT    = 7'(ROUND_SECONDS);
  localparam logic [CNT_W-1:0] READY_INIT = CNT_W'(READY_TICKS);
  localparam logic [CNT_W-1:0] OVER_INIT  = CNT_W'(OVER_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [1:0]       WINS_TGT   = 2'(WINS_TO_MATCH);
  localparam logic [1:0]       LAST_ROUND = 2'(MAX_ROUNDS);

  logic [4:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;
  logic             finish_q, finish_d;
  logic             round_reset_q, round_reset_d;
  logic [1:0]       countdown_q, countdown_d;
  logic [6:0]       round_time_q, round_time_d;
  logic [1:0]       round_num_q, round_num_d;
  logic [1:0]       p0_wins_q, p0_wins_d;
  logic [1:0]       p1_wins_q, p1_wins_d;
  logic [1:0]       round_winner_q, round_winner_d;
  logic [1:0]       match_winner_q, match_winner_d;

  logic [1:0]       fight_result;
  logic [CNT_W:0]   cnt_plus;

  // Next-state and registered-output computation for one tick.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    half_d         = half_q;
    round_reset_d  = 1'b0;
    round_time_d   = round_time_q;
    round_num_d    = round_num_q;
    p0_wins_d      = p0_wins_q;
    p1_wins_d      = p1_wins_q;
    round_winner_d = round_winner_q;
    match_winner_d = match_winner_q;
    fight_result   = W_NONE;

    case (state_q)
      S_IDLE: begin
        if (bus.start_btn) begin
          state_d       = S_READY;
          cnt_d         = READY_INIT;
          round_reset_d = 1'b1;
        end
      end

      S_READY: begin
        if (cnt_q == CNT_ONE) begin
          state_d        = S_FIGHT;
          cnt_d          = '0;
          round_time_d   = RT_INIT;
          half_d         = 1'b0;
          round_winner_d = W_NONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_FIGHT: begin
        if (bus.p0_health == 4'd0 && bus.p1_health == 4'd0) begin
          fight_result = W_DRAW;
        end else if (bus.p0_health == 4'd0) begin
          fight_result = W_P1;
        end else if (bus.p1_health == 4'd0) begin
          fight_result = W_P0;
        end else if (round_time_q == 7'd0) begin
          if (bus.p0_health > bus.p1_health) begin
            fight_result = W_P0;
          end else if (bus.p0_health < bus.p1_health) begin
            fight_result = W_P1;
          end else begin
            fight_result = W_DRAW;
          end
        end else if (half_q) begin
          round_time_d = round_time_q - 7'd1;
          half_d       = 1'b0;
        end else begin
          half_d = 1'b1;
        end

        if (fight_result != W_NONE) begin
          state_d        = S_ROUND_OVER;
          cnt_d          = OVER_INIT;
          round_winner_d = fight_result;
          if (fight_result == W_P0 && p0_wins_q != 2'd3) begin
            p0_wins_d = p0_wins_q + 2'd1;
          end
          if (fight_result == W_P1 && p1_wins_q != 2'd3) begin
            p1_wins_d = p1_wins_q + 2'd1;
          end
        end
      end

      S_ROUND_OVER: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d = '0;
          if (p0_wins_q == WINS_TGT) begin
            state_d        = S_MATCH_OVER;
            match_winner_d = W_P0;
          end else if (p1_wins_q == WINS_TGT) begin
            state_d        = S_MATCH_OVER;
            match_winner_d = W_P1;
          end else if (round_num_q == LAST_ROUND) begin
            state_d = S_MATCH_OVER;
            if (p0_wins_q > p1_wins_q) begin
              match_winner_d = W_P0;
            end else if (p0_wins_q < p1_wins_q) begin
              match_winner_d = W_P1;
            end else begin
              match_winner_d = W_DRAW;
            end
          end else begin
            state_d       = S_READY;
            cnt_d         = READY_INIT;
            round_num_d   = round_num_q + 2'd1;
            round_reset_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_MATCH_OVER: begin
        if (bus.start_btn) begin
          state_d        = S_READY;
          cnt_d          = READY_INIT;
          round_reset_d  = 1'b1;
          p0_wins_d      = 2'd0;
          p1_wins_d      = 2'd0;
          round_num_d    = 2'd1;
          match_winner_d = W_NONE;
          round_winner_d = W_NONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    finish_d = (state_d != S_FIGHT);
    cnt_plus = {1'b0, cnt_d} + (CNT_W + 1)'(1);
    if (state_d == S_READY) begin
      countdown_d = 2'(cnt_plus >> 1);
    end else begin
      countdown_d = 2'd0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge slowed_shield_clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      half_q         <= 1'b0;
      finish_q       <= 1'b1;
      round_reset_q  <= 1'b0;
      countdown_q    <= 2'd0;
      round_time_q   <= RT_INIT;
      round_num_q    <= 2'd1;
      p0_wins_q      <= 2'd0;
      p1_wins_q      <= 2'd0;
      round_winner_q <= W_NONE;
      match_winner_q <= W_NONE;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      half_q         <= half_d;
      finish_q       <= finish_d;
      round_reset_q  <= round_reset_d;
      countdown_q    <= countdown_d;
      round_time_q   <= round_time_d;
      round_num_q    <= round_num_d;
      p0_wins_q      <= p0_wins_d;
      p1_wins_q      <= p1_wins_d;
      round_winner_q <= round_winner_d;
      match_winner_q <= match_winner_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.finish       = finish_q;
  assign bus.round_reset  = round_reset_q;
  assign bus.countdown    = countdown_q;
  assign bus.round_time   = round_time_q;
  assign bus.round_num    = round_num_q;
  assign bus.p0_wins      = p0_wins_q;
  assign bus.p1_wins      = p1_wins_q;
  assign bus.round_winner = round_winner_q;
  assign bus.match_winner = match_winner_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: reset/countdown vector table,
// directed match sequences and randomized play against a tick-level model.
module tb_round_controller;

  localparam int RS = 60;
  localparam int WT = 2;
  localparam int MR = 3;
  localparam int RT = 6;
  localparam int OT = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_READY = 1;
  localparam int PH_FIGHT = 2;
  localparam int PH_OVER  = 3;
  localparam int PH_MATCH = 4;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_READY = 5'b00010;
  localparam logic [4:0] ST_FIGHT = 5'b00100;
  localparam logic [4:0] ST_OVER  = 5'b01000;
  localparam logic [4:0] ST_MATCH = 5'b10000;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  round_controller_if bus();

  round_controller #(
    .ROUND_SECONDS(RS), .WINS_TO_MATCH(WT), .MAX_ROUNDS(MR),
    .READY_TICKS(RT), .OVER_TICKS(OT)
  ) dut (
    .slowed_shield_clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase, ticks spent in the phase, half-seconds fought.
  int m_phase, m_age, m_ft, m_rt, m_round, m_w0, m_w1, m_rw, m_mw;
  bit m_rr;

  function automatic void model_reset();
    m_phase = PH_IDLE; m_age = 0; m_ft = 0; m_rt = RS; m_round = 1;
    m_w0 = 0; m_w1 = 0; m_rw = 0; m_mw = 0; m_rr = 1'b0;
  endfunction

  function automatic void model_enter_ready();
    m_phase = PH_READY; m_age = 1; m_rr = 1'b1;
  endfunction

  function automatic void model_step(input bit r, input bit st, input int h0, input int h1);
    int res;
    if (!r) begin
      model_reset();
      return;
    end
    m_rr = 1'b0;
    res  = 0;
    case (m_phase)
      PH_IDLE: if (st) model_enter_ready();
      PH_READY: begin
        if (m_age == RT) begin
          m_phase = PH_FIGHT; m_age = 1; m_ft = 0; m_rt = RS; m_rw = 0;
        end else m_age++;
      end
      PH_FIGHT: begin
        if (h0 == 0 && h1 == 0) res = 3;
        else if (h0 == 0) res = 2;
        else if (h1 == 0) res = 1;
        else if (m_ft >= 2 * RS) res = (h0 > h1) ? 1 : (h0 < h1) ? 2 : 3;
        else begin
          m_ft++;
          m_rt = RS - m_ft / 2;
        end
        if (res != 0) begin
          m_rw = res;
          if (res == 1 && m_w0 < 3) m_w0++;
          if (res == 2 && m_w1 < 3) m_w1++;
          m_phase = PH_OVER; m_age = 1;
        end
      end
      PH_OVER: begin
        if (m_age == OT) begin
          if (m_w0 == WT) begin m_mw = 1; m_phase = PH_MATCH; end
          else if (m_w1 == WT) begin m_mw = 2; m_phase = PH_MATCH; end
          else if (m_round == MR) begin
            m_mw = (m_w0 > m_w1) ? 1 : (m_w0 < m_w1) ? 2 : 3;
            m_phase = PH_MATCH;
          end else begin
            m_round++;
            model_enter_ready();
          end
        end else m_age++;
      end
      default: begin
        if (st) begin
          m_w0 = 0; m_w1 = 0; m_round = 1; m_mw = 0; m_rw = 0;
          model_enter_ready();
        end
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("m_state", 32'(bus.state), 32'(1 << m_phase));
    chk("m_finish", 32'(bus.finish), 32'(m_phase != PH_FIGHT));
    chk("m_round_reset", 32'(bus.round_reset), 32'(m_rr));
    chk("m_countdown", 32'(bus.countdown), 32'((m_phase == PH_READY) ? (RT - m_age + 2) / 2 : 0));
    chk("m_round_time", 32'(bus.round_time), 32'(m_rt));
    chk("m_round_num", 32'(bus.round_num), 32'(m_round));
    chk("m_p0_wins", 32'(bus.p0_wins), 32'(m_w0));
    chk("m_p1_wins", 32'(bus.p1_wins), 32'(m_w1));
    chk("m_round_winner", 32'(bus.round_winner), 32'(m_rw));
    chk("m_match_winner", 32'(bus.match_winner), 32'(m_mw));
  endtask

  // One shield tick: advance the model with the current inputs, then compare.
  task automatic tick();
    model_step(rst_n, bus.start_btn, int'(bus.p0_health), int'(bus.p1_health));
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic run_until_rt(input int target);
    int n = 0;
    while (!(bus.state == ST_FIGHT && int'(bus.round_time) == target) && n < 400) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 400) begin
      n_errors++;
      $display("FAIL wait_round_time: never reached FIGHT with round_time=%0d (at %0d)",
               target, bus.round_time);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    bit         rst;
    bit         st;
    logic [4:0] exp_state;
    bit         exp_fin;
    bit         exp_rr;
    logic [1:0] exp_cd;
    logic [6:0] exp_rt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, ST_IDLE,  1'b1, 1'b0, 2'd0, 7'd60};
    vecs[1]  = '{1'b0, 1'b0, ST_IDLE,  1'b1, 1'b0, 2'd0, 7'd60};
    vecs[2]  = '{1'b1, 1'b0, ST_IDLE,  1'b1, 1'b0, 2'd0, 7'd60};
    vecs[3]  = '{1'b1, 1'b1, ST_READY, 1'b1, 1'b1, 2'd3, 7'd60};
    vecs[4]  = '{1'b1, 1'b0, ST_READY, 1'b1, 1'b0, 2'd3, 7'd60};
    vecs[5]  = '{1'b1, 1'b1, ST_READY, 1'b1, 1'b0, 2'd2, 7'd60};
    vecs[6]  = '{1'b1, 1'b0, ST_READY, 1'b1, 1'b0, 2'd2, 7'd60};
    vecs[7]  = '{1'b1, 1'b0, ST_READY, 1'b1, 1'b0, 2'd1, 7'd60};
    vecs[8]  = '{1'b1, 1'b0, ST_READY, 1'b1, 1'b0, 2'd1, 7'd60};
    vecs[9]  = '{1'b1, 1'b0, ST_FIGHT, 1'b0, 1'b0, 2'd0, 7'd60};
    vecs[10] = '{1'b1, 1'b0, ST_FIGHT, 1'b0, 1'b0, 2'd0, 7'd60};
    vecs[11] = '{1'b1, 1'b0, ST_FIGHT, 1'b0, 1'b0, 2'd0, 7'd59};

    model_reset();
    rst_n = 1'b0;
    bus.start_btn = 1'b0;
    bus.p0_health = 4'd15;
    bus.p1_health = 4'd15;
    #2;

    // Reset, start, countdown and first seconds of the fight.
    for (int i = 0; i < 12; i++) begin
      rst_n = vecs[i].rst;
      bus.start_btn = vecs[i].st;
      tick();
      chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vecs[i].exp_state));
      chk($sformatf("vec%0d_finish", i), 32'(bus.finish), 32'(vecs[i].exp_fin));
      chk($sformatf("vec%0d_round_reset", i), 32'(bus.round_reset), 32'(vecs[i].exp_rr));
      chk($sformatf("vec%0d_countdown", i), 32'(bus.countdown), 32'(vecs[i].exp_cd));
      chk($sformatf("vec%0d_round_time", i), 32'(bus.round_time), 32'(vecs[i].exp_rt));
    end
    bus.start_btn = 1'b0;

    // Full-length round ending in a timeout won by P0 on health.
    run_until_rt(0);
    chk("rt0_state", 32'(bus.state), 32'(ST_FIGHT));
    bus.p0_health = 4'd9;
    bus.p1_health = 4'd4;
    tick();
    chk("timeout_state", 32'(bus.state), 32'(ST_OVER));
    chk("timeout_winner", 32'(bus.round_winner), 32'd1);
    chk("timeout_p0_wins", 32'(bus.p0_wins), 32'd1);
    chk("timeout_finish", 32'(bus.finish), 32'd1);
    bus.p0_health = 4'd15;
    bus.p1_health = 4'd15;
    ticks(3);
    chk("over_hold_state", 32'(bus.state), 32'(ST_OVER));
    tick();
    chk("r2_state", 32'(bus.state), 32'(ST_READY));
    chk("r2_round_num", 32'(bus.round_num), 32'd2);
    chk("r2_round_reset", 32'(bus.round_reset), 32'd1);
    tick();
    chk("r2_round_reset_drop", 32'(bus.round_reset), 32'd0);

    // KO mid-round gives P0 the match after round 2.
    run_until_rt(37);
    bus.p1_health = 4'd0;
    tick();
    chk("ko_state", 32'(bus.state), 32'(ST_OVER));
    chk("ko_winner", 32'(bus.round_winner), 32'd1);
    chk("ko_p0_wins", 32'(bus.p0_wins), 32'd2);
    bus.p1_health = 4'd15;
    ticks(4);
    chk("match_state", 32'(bus.state), 32'(ST_MATCH));
    chk("match_winner", 32'(bus.match_winner), 32'd1);
    chk("match_round_num", 32'(bus.round_num), 32'd2);
    ticks(3);
    chk("match_hold", 32'(bus.state), 32'(ST_MATCH));
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    chk("rematch_state", 32'(bus.state), 32'(ST_READY));
    chk("rematch_rr", 32'(bus.round_reset), 32'd1);
    chk("rematch_wins", 32'({bus.p0_wins, bus.p1_wins}), 32'd0);
    chk("rematch_round_num", 32'(bus.round_num), 32'd1);
    chk("rematch_mw", 32'(bus.match_winner), 32'd0);

    // Three double KOs: draw match after the round cap.
    for (int r = 0; r < 3; r++) begin
      run_until_rt(58);
      bus.p0_health = 4'd0;
      bus.p1_health = 4'd0;
      tick();
      chk($sformatf("dko%0d_winner", r), 32'(bus.round_winner), 32'd3);
      chk($sformatf("dko%0d_wins", r), 32'({bus.p0_wins, bus.p1_wins}), 32'd0);
      bus.p0_health = 4'd15;
      bus.p1_health = 4'd15;
      ticks(4);
    end
    chk("dko_match_state", 32'(bus.state), 32'(ST_MATCH));
    chk("dko_match_winner", 32'(bus.match_winner), 32'd3);
    chk("dko_round_num", 32'(bus.round_num), 32'd3);

    // Timeout with equal health is a draw.
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    bus.p0_health = 4'd7;
    bus.p1_health = 4'd7;
    run_until_rt(0);
    tick();
    chk("tdraw_state", 32'(bus.state), 32'(ST_OVER));
    chk("tdraw_winner", 32'(bus.round_winner), 32'd3);
    bus.p0_health = 4'd15;
    bus.p1_health = 4'd15;

    // Reset in the middle of a fight.
    run_until_rt(20);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_state", 32'(bus.state), 32'(ST_IDLE));
    chk("rst_finish", 32'(bus.finish), 32'd1);
    chk("rst_round_time", 32'(bus.round_time), 32'(RS));
    chk("rst_round_num", 32'(bus.round_num), 32'd1);
    chk("rst_round_reset", 32'(bus.round_reset), 32'd0);
    chk("rst_winner", 32'(bus.round_winner), 32'd0);

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      bus.start_btn = ($urandom_range(0, 7) == 0);
      bus.p0_health = ($urandom_range(0, 49) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      bus.p1_health = ($urandom_range(0, 49) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
